// File: rtl/lut_neuron_array_pipe.sv
// -----------------------------------------------------------------------------
// lut_neuron_array_pipe
//
// An array of NEURONS runtime-programmable LUT neurons. Each neuron owns a
// truth table of 2^IN_BITS entries, each OUT_BITS wide. The tables live in
// distributed RAM and are loaded through a single write port. One input beat
// carries an address for every neuron; all neurons are looked up in parallel,
// and the combined result leaves through a valid/ready output register.
//
// With REG_IN=1 an input register (s1) sits in front of the table read, so the
// beat-to-result latency is 1 + REG_IN cycles. Both stages are elastic: a
// stage takes a new beat whenever it is empty or its contents move on in the
// same cycle. This gives one beat per cycle under continuous ready.
//
// The write port has priority over the stream. While prog_en is high no new
// beat is accepted. Beats already in s1 keep moving. A lookup that reads the
// entry being written in the same cycle sees the old contents.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset (pipeline only, not tables)
//   in_valid     input beat valid
//   in_ready     block can accept an input beat
//   in_data      neuron n address at [n*IN_BITS +: IN_BITS]
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
//   out_data     neuron n result at [n*OUT_BITS +: OUT_BITS]
//   prog_en      table write strobe
//   prog_neuron  target neuron index (out-of-range indices are ignored)
//   prog_addr    table entry address
//   prog_data    entry value
// -----------------------------------------------------------------------------
module lut_neuron_array_pipe #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int NEURONS  = 4,
  parameter int REG_IN   = 0,
  parameter int NIDX_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,

  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,

  input  logic                         prog_en,
  input  logic [NIDX_W-1:0]            prog_neuron,
  input  logic [IN_BITS-1:0]           prog_addr,
  input  logic [OUT_BITS-1:0]          prog_data
);

  localparam int DEPTH = 1 << IN_BITS;

  // The table index needs only enough bits to count NEURONS. prog_neuron may
  // be wider, so the range check below uses all of its bits.
  localparam int SEL_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  // The limit is widened by one bit so that NEURONS == 2^NIDX_W still fits.
  localparam logic [NIDX_W:0] NEURON_LIMIT = (NIDX_W + 1)'(NEURONS);

  // ---------------------------------------------------------------------------
  // Truth tables
  // ---------------------------------------------------------------------------
  logic [OUT_BITS-1:0] tbl [NEURONS][DEPTH];

  logic             wr_hit;
  logic [SEL_W-1:0] wr_sel;

  assign wr_hit = prog_en && ({1'b0, prog_neuron} < NEURON_LIMIT);
  assign wr_sel = prog_neuron[SEL_W-1:0];

  // NOTE: the table has no reset branch. Memories are not cleared by a reset;
  // a reset port on distributed RAM would force it into flip-flops. The tables
  // keep their contents across rst. Power-up contents come from the bitstream.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      tbl[wr_sel][prog_addr] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Parallel lookup
  // ---------------------------------------------------------------------------
  // rd_addr and rd_valid come from either the raw input or the s1 register.
  // The read is asynchronous. The write above commits at the clock edge, so a
  // lookup in the same cycle as a write to that entry still sees the old value.
  logic                         rd_valid;
  logic [NEURONS*IN_BITS-1:0]   rd_addr;
  logic [NEURONS*OUT_BITS-1:0]  rd_data;

  for (genvar n = 0; n < NEURONS; n++) begin : g_lookup
    assign rd_data[n*OUT_BITS +: OUT_BITS] = tbl[n][rd_addr[n*IN_BITS +: IN_BITS]];
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  // The output register takes a new value whenever it is empty or its current
  // beat is consumed this cycle.
  logic out_adv;

  assign out_adv = !out_valid || out_ready;

  // ---------------------------------------------------------------------------
  // Input side: optional s1 register
  // ---------------------------------------------------------------------------
  if (REG_IN != 0) begin : g_reg_in
    logic                       s1_valid;
    logic [NEURONS*IN_BITS-1:0] s1_data;
    logic                       s1_load;

    // s1 can load when it is empty or its beat moves to the output this cycle.
    assign s1_load  = !s1_valid || out_adv;
    assign in_ready = s1_load && !prog_en;

    // NOTE: sequential state is written with non-blocking assignments only.
    // Every register then samples values from before the edge, so the order of
    // the always_ff blocks does not matter.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid <= 1'b0;
      end else if (s1_load) begin
        s1_valid <= in_valid && in_ready;
      end
    end

    // The data path carries no reset. Only the valid bit decides whether the
    // contents mean anything.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        s1_data <= in_data;
      end
    end

    assign rd_valid = s1_valid;
    assign rd_addr  = s1_data;
  end else begin : g_no_reg_in
    assign in_ready = out_adv && !prog_en;
    assign rd_valid = in_valid && in_ready;
    assign rd_addr  = in_data;
  end

  // out_data changes only when a new beat is captured. It holds while the
  // output is stalled, and it also holds after the beat drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (out_adv) begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        out_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_array_pipe.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_array_pipe
//
// Two instances share every input: dut0 has REG_IN=0 and dut1 has REG_IN=1.
// Each test sequence checks the instance it targets.
//
// Both instances use NIDX_W=3 so that neuron indices 4..7 can be presented
// and shown to be ignored.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled in the
// same region or 1 unit later, away from the active edge.
// -----------------------------------------------------------------------------
module tb_lut_neuron_array_pipe;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int NEURONS  = 4;
  localparam int NIDX_W   = 3;

  logic                         clk;
  logic                         rst;
  logic                         in_valid;
  logic [NEURONS*IN_BITS-1:0]   in_data;
  logic                         out_ready;
  logic                         prog_en;
  logic [NIDX_W-1:0]            prog_neuron;
  logic [IN_BITS-1:0]           prog_addr;
  logic [OUT_BITS-1:0]          prog_data;

  logic                         in_ready0, out_valid0;
  logic [NEURONS*OUT_BITS-1:0]  out_data0;
  logic                         in_ready1, out_valid1;
  logic [NEURONS*OUT_BITS-1:0]  out_data1;

  lut_neuron_array_pipe #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS),
    .REG_IN(0), .NIDX_W(NIDX_W)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .prog_en(prog_en), .prog_neuron(prog_neuron),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  lut_neuron_array_pipe #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS),
    .REG_IN(1), .NIDX_W(NIDX_W)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .prog_en(prog_en), .prog_neuron(prog_neuron),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] in_data;
    logic [7:0]  exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference copy of the tables, kept up to date by the prog task.
  logic [1:0] model [4][64];

  vec_t       vecs [5];
  vec_t       stream [16];
  logic [23:0] bp [3];
  logic [7:0]  got [$];
  int          accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int n, input int a, input logic [1:0] d);
    prog_en     = 1'b1;
    prog_neuron = 3'(n);
    prog_addr   = 6'(a);
    prog_data   = d;
    step();
    prog_en = 1'b0;
    if (n < 4) model[n][a] = d;
  endtask

  function automatic logic [7:0] model_lookup(input logic [23:0] d);
    logic [7:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) r[n*2 +: 2] = model[n][d[n*6 +: 6]];
    return r;
  endfunction

  initial begin
    // Directed vectors for the first test. Packing is {n3, n2, n1, n0}.
    // Programmed entries: n0[4]=3, n1[13]=2, n2[63]=1, n3[42]=3.
    vecs[0] = '{{6'd0,  6'd0,  6'd13, 6'd4 }, 8'h0B};
    vecs[1] = '{{6'd42, 6'd63, 6'd0,  6'd0 }, 8'hD0};
    vecs[2] = '{{6'd42, 6'd63, 6'd13, 6'd4 }, 8'hDB};
    vecs[3] = '{{6'd4,  6'd13, 6'd4,  6'd13}, 8'h00};
    vecs[4] = '{{6'd0,  6'd0,  6'd0,  6'd0 }, 8'h00};
    bp[0] = vecs[2].in_data;   // result DB
    bp[1] = vecs[0].in_data;   // result 0B
    bp[2] = vecs[1].in_data;   // result D0

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    prog_en = 1'b0; prog_neuron = '0; prog_addr = '0; prog_data = '0;
    for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) model[n][a] = 2'b00;

    // ---- reset state -------------------------------------------------------
    step(); step();
    check("rst_out_valid0", out_valid0, 0);
    check("rst_out_data0",  out_data0,  0);
    check("rst_out_valid1", out_valid1, 0);
    check("rst_out_data1",  out_data1,  0);
    rst = 1'b0;
    #1;
    check("rst_in_ready0", in_ready0, 1);
    check("rst_in_ready1", in_ready1, 1);

    // Start from a known all-zero table state.
    for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) prog(n, a, 2'b00);

    // ---- test 1: programmed lookups, REG_IN=0, 1-cycle latency -------------
    prog(0, 4, 2'b11); prog(1, 13, 2'b10); prog(2, 63, 2'b01); prog(3, 42, 2'b11);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].in_data;
      #1;
      check($sformatf("t1_in_ready[%0d]", i), in_ready0, 1);
      step();
      check($sformatf("t1_out_valid[%0d]", i), out_valid0, 1);
      check($sformatf("t1_out_data[%0d]", i), out_data0, vecs[i].exp);
    end
    in_valid = 1'b0;
    step();
    check("t1_drained", out_valid0, 0);

    // ---- test 2: backpressure on REG_IN=1 ----------------------------------
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepted  = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = bp[(accepted < 3) ? accepted : 2];
      #1;
      if (in_ready1) accepted++;
      step();
    end
    check("t2_accepted", accepted, 2);
    check("t2_in_ready_stalled", in_ready1, 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t2_hold_valid[%0d]", c), out_valid1, 1);
      check($sformatf("t2_hold_data[%0d]", c), out_data1, 8'hDB);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      if (out_valid1) got.push_back(out_data1);
      step();
    end
    check("t2_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("t2_first", got[0], 8'hDB);
      check("t2_second", got[1], 8'h0B);
    end

    // ---- test 3: continuous stream, both latencies -------------------------
    // Pattern used from here on: neuron n, entry a holds (a + n) mod 4.
    for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) prog(n, a, 2'((a + n) & 3));
    for (int k = 0; k < 16; k++) begin
      stream[k].in_data = 24'($urandom);
      stream[k].exp     = model_lookup(stream[k].in_data);
    end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        in_valid = 1'b1;
        in_data  = stream[k].in_data;
        #1;
        check($sformatf("t3_in_ready1[%0d]", k), in_ready1, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k < 16) begin
        check($sformatf("t3_valid0[%0d]", k), out_valid0, 1);
        check($sformatf("t3_data0[%0d]", k), out_data0, stream[k].exp);
      end
      if (k >= 1 && k <= 16) begin
        check($sformatf("t3_valid1[%0d]", k - 1), out_valid1, 1);
        check($sformatf("t3_data1[%0d]", k - 1), out_data1, stream[k - 1].exp);
      end
    end
    step();

    // ---- test 4: read/write collision on REG_IN=1 --------------------------
    // Neuron 0 entry 41 holds 01. The other neurons read entry 0 (1, 2, 3).
    in_valid = 1'b1;
    in_data  = {6'd0, 6'd0, 6'd0, 6'd41};
    #1;
    check("t4_accept", in_ready1, 1);
    step();
    in_valid    = 1'b0;
    prog_en     = 1'b1;
    prog_neuron = 3'd0;
    prog_addr   = 6'd41;
    prog_data   = 2'b00;
    #1;
    check("t4_prog_blocks_input", in_ready1, 0);
    step();
    prog_en = 1'b0;
    model[0][41] = 2'b00;
    check("t4_old_valid", out_valid1, 1);
    check("t4_old_value", out_data1, 8'hE5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t4_new_valid", out_valid1, 1);
    check("t4_new_value", out_data1, 8'hE4);
    step();

    // ---- test 5: guards -----------------------------------------------------
    in_valid    = 1'b1;
    in_data     = {6'd7, 6'd7, 6'd7, 6'd7};
    prog_en     = 1'b1;
    prog_neuron = 3'd4;
    prog_addr   = 6'd7;
    prog_data   = 2'b00;
    #1;
    check("t5_in_ready0_c0", in_ready0, 0);
    check("t5_in_ready1_c0", in_ready1, 0);
    step();
    prog_neuron = 3'd7;
    #1;
    check("t5_in_ready0_c1", in_ready0, 0);
    check("t5_in_ready1_c1", in_ready1, 0);
    step();
    prog_en  = 1'b0;
    in_valid = 1'b0;
    check("t5_no_beat0", out_valid0, 0);
    check("t5_no_beat1", out_valid1, 0);
    step();
    check("t5_no_beat1_late", out_valid1, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t5_lookup_valid", out_valid0, 1);
    check("t5_tables_unchanged", out_data0, 8'h93);
    step();

    // ---- test 6: reset mid-stream, write during reset ----------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = stream[0].in_data;
    step(); step();
    check("t6_pre_valid0", out_valid0, 1);
    check("t6_pre_valid1", out_valid1, 1);
    in_valid    = 1'b0;
    rst         = 1'b1;
    prog_en     = 1'b1;
    prog_neuron = 3'd1;
    prog_addr   = 6'd9;
    prog_data   = 2'b11;
    step();
    rst     = 1'b0;
    prog_en = 1'b0;
    model[1][9] = 2'b11;
    check("t6_rst_valid0", out_valid0, 0);
    check("t6_rst_data0",  out_data0,  0);
    check("t6_rst_valid1", out_valid1, 0);
    check("t6_rst_data1",  out_data1,  0);
    out_ready = 1'b1;
    step();
    check("t6_s1_dropped", out_valid1, 0);
    in_valid = 1'b1;
    in_data  = {6'd7, 6'd7, 6'd9, 6'd41};
    step();
    in_valid = 1'b0;
    check("t6_after_valid0", out_valid0, 1);
    check("t6_after_data0", out_data0, 8'h9C);
    step();
    check("t6_after_valid1", out_valid1, 1);
    check("t6_after_data1", out_data1, 8'h9C);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
